// File: rtl/plca_pkg.sv
// Shared definitions for the PLCA coordinator beacon generator.
package plca_pkg;

  localparam int PLCA_ID_W     = 8;
  localparam int BEACON_BT_DEF = 20;
  localparam int TO_BT_DEF     = 32;

  typedef enum logic [1:0] {
    DISABLED    = 2'd0,
    SEND_BEACON = 2'd1,
    WAIT_TO     = 2'd2,
    ACTIVE      = 2'd3
  } plca_state_t;

endpackage

// File: rtl/plca_bt_counter.sv
// Bit-time counter: clears on request, counts bt_tick while enabled and flags
// the tick on which the programmed limit is reached.
module plca_bt_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bt_tick,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // Counter register: clear wins over counting; hold when not enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          count <= '0;
    else if (clr)          count <= '0;
    else if (en && bt_tick) count <= count + 1'b1;
  end

  assign expire = en && bt_tick && (count == (limit - 1'b1));

endmodule

// File: rtl/plca_beacon_gen.sv
// PLCA coordinator: sends BEACON, then walks cur_id through the transmit
// opportunities of the cycle. ADVANCE is not a state; it is resolved inside
// the transition out of WAIT_TO / ACTIVE.
//
//   state       | meaning
//   DISABLED    | not coordinator or PLCA off, outputs idle
//   SEND_BEACON | BEACON on the wire for BEACON_BT bit times
//   WAIT_TO     | transmit opportunity for cur_id, to_timer running
//   ACTIVE      | channel busy, to_timer held until carrier drops
module plca_beacon_gen
  import plca_pkg::*;
#(
  parameter int BEACON_BT = BEACON_BT_DEF,
  parameter int TO_BT     = TO_BT_DEF,
  parameter int ID_W      = PLCA_ID_W,
  parameter int CNT_W     = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            bt_tick,
  input  logic            plca_en,
  input  logic [ID_W-1:0] local_node_id,
  input  logic [ID_W-1:0] node_count,
  input  logic            crs,
  output logic            beacon,
  output logic [ID_W-1:0] cur_id,
  output logic            tx_op,
  output logic            to_done,
  output logic            cycle_start
);

  plca_state_t     state, state_nxt;
  logic [ID_W-1:0] cur_id_nxt;
  logic [ID_W-1:0] last_id;
  logic            active, adv;
  logic            cnt_clr, cnt_en, expire;
  logic [CNT_W-1:0] cnt_limit, count;
  logic            beacon_d, tx_op_d, to_done_d, cycle_start_d;

  assign active    = plca_en && (local_node_id == '0);
  // node_count of 0 or 1 both mean a single opportunity (ID 0 only).
  assign last_id   = (node_count < ID_W'(2)) ? '0 : node_count - 1'b1;
  assign cnt_limit = (state == SEND_BEACON) ? CNT_W'(BEACON_BT) : CNT_W'(TO_BT);
  assign cnt_en    = (state == SEND_BEACON) || (state == WAIT_TO);
  // Every phase change (including WAIT_TO -> WAIT_TO on advance) restarts timing.
  assign cnt_clr   = (state_nxt != state) || adv;

  plca_bt_counter #(.CNT_W(CNT_W)) u_bt_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .bt_tick (bt_tick),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .limit   (cnt_limit),
    .count   (count),
    .expire  (expire)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= DISABLED;
      cur_id      <= '0;
      beacon      <= 1'b0;
      tx_op       <= 1'b0;
      to_done     <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_id      <= cur_id_nxt;
      beacon      <= beacon_d;
      tx_op       <= tx_op_d;
      to_done     <= to_done_d;
      cycle_start <= cycle_start_d;
    end
  end

  // Next state and next cur_id, with the advance step folded in.
  always_comb begin
    state_nxt  = state;
    cur_id_nxt = cur_id;
    adv        = 1'b0;
    if (!active) begin
      state_nxt  = DISABLED;
      cur_id_nxt = '0;
    end else begin
      case (state)
        DISABLED: begin
          state_nxt  = SEND_BEACON;
          cur_id_nxt = '0;
        end
        SEND_BEACON: begin
          // crs is our own BEACON here, so it is not looked at.
          if (expire) begin
            state_nxt  = WAIT_TO;
            cur_id_nxt = '0;
          end
        end
        WAIT_TO: begin
          if (crs)         state_nxt = ACTIVE;
          else if (expire) adv       = 1'b1;
        end
        ACTIVE: begin
          if (!crs) adv = 1'b1;
        end
        default: state_nxt = DISABLED;
      endcase
      if (adv) begin
        // >= rather than == so a shrinking node_count ends the cycle cleanly.
        if (cur_id >= last_id) begin
          state_nxt  = SEND_BEACON;
          cur_id_nxt = '0;
        end else begin
          state_nxt  = WAIT_TO;
          cur_id_nxt = cur_id + 1'b1;
        end
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    beacon_d      = (state_nxt == SEND_BEACON);
    cycle_start_d = (state_nxt == SEND_BEACON) && (state != SEND_BEACON);
    to_done_d     = active && (state == WAIT_TO) && !crs && expire;
    tx_op_d       = (state_nxt == WAIT_TO) && (cur_id_nxt == local_node_id) && !crs;
  end

endmodule

// File: tb/tb_plca_beacon_gen.sv
// Directed bench for plca_beacon_gen with default timer lengths (20 / 32).
// Edge counter ec counts rising edges since the last (re)start; expected
// values are the hand-worked edge numbers of each event.
module tb_plca_beacon_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bt_tick;
  logic       plca_en;
  logic [7:0] local_node_id;
  logic [7:0] node_count;
  logic       crs;
  logic       beacon;
  logic [7:0] cur_id;
  logic       tx_op;
  logic       to_done;
  logic       cycle_start;

  int checks = 0;
  int errors = 0;
  int ec = 0;
  int tick_div = 1;
  int td_cnt = 0;
  int bc_cnt = 0;
  int cs_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  plca_beacon_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bt_tick       (bt_tick),
    .plca_en       (plca_en),
    .local_node_id (local_node_id),
    .node_count    (node_count),
    .crs           (crs),
    .beacon        (beacon),
    .cur_id        (cur_id),
    .tx_op         (tx_op),
    .to_done       (to_done),
    .cycle_start   (cycle_start)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (ec=%0d)", tag, obs, exp, ec);
    end
  endtask

  // One rising edge; sample 1 time unit later and set the tick for the next edge.
  // With tick_div > 1, ticks land on edges 1, 1+div, 1+2*div, ...
  task automatic step();
    @(posedge clk);
    #1;
    ec++;
    if (to_done)     td_cnt++;
    if (beacon)      bc_cnt++;
    if (cycle_start) cs_cnt++;
    bt_tick = (tick_div == 1) ? 1'b1 : (((ec + 1) % tick_div) == 1);
  endtask

  task automatic run_to(input int n);
    while (ec < n) step();
  endtask

  // Drop enable for one edge so the DUT is DISABLED, then enable and zero ec.
  task automatic restart(input int div, input logic [7:0] nc);
    plca_en = 1'b0;
    step();
    tick_div   = div;
    node_count = nc;
    local_node_id = 8'd0;
    crs     = 1'b0;
    plca_en = 1'b1;
    ec      = 0;
    bt_tick = (tick_div == 1) ? 1'b1 : 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bt_tick = 1'b1;
    plca_en = 1'b1;
    local_node_id = 8'd0;
    node_count = 8'd4;
    crs = 1'b0;

    step(); step();
    check_val("rst_beacon", beacon, 0);
    check_val("rst_cur_id", cur_id, 0);
    check_val("rst_cycle_start", cycle_start, 0);

    // Start, then assert reset in the middle of BEACON.
    reset_n = 1'b1; ec = 0;
    run_to(5);
    check_val("pre_rst_beacon", beacon, 1);
    #3 reset_n = 1'b0;
    #1;
    check_val("async_rst_beacon", beacon, 0);
    check_val("async_rst_tx_op", tx_op, 0);
    check_val("async_rst_cur_id", cur_id, 0);
    step();
    reset_n = 1'b1; ec = 0;

    // Free-running cycle, node_count = 4, tick every clock.
    run_to(1);
    check_val("c1_cycle_start", cycle_start, 1);
    check_val("c1_beacon", beacon, 1);
    run_to(2);
    check_val("c1_cs_pulse", cycle_start, 0);
    run_to(20);
    check_val("c1_beacon_last", beacon, 1);
    run_to(21);
    check_val("c1_beacon_end", beacon, 0);
    check_val("c1_tx_op0", tx_op, 1);
    run_to(52);
    check_val("c1_id0_end", cur_id, 0);
    check_val("c1_no_td", to_done, 0);
    run_to(53);
    check_val("c1_id1", cur_id, 1);
    check_val("c1_to_done", to_done, 1);
    check_val("c1_tx_op1", tx_op, 0);
    run_to(54);
    check_val("c1_td_pulse", to_done, 0);
    run_to(85);
    check_val("c1_id2", cur_id, 2);
    run_to(117);
    check_val("c1_id3", cur_id, 3);
    run_to(148);
    check_val("c1_pre_beacon", beacon, 0);
    run_to(149);
    check_val("c2_beacon", beacon, 1);
    check_val("c2_cycle_start", cycle_start, 1);
    check_val("c2_cur_id", cur_id, 0);

    // Channel activity 10 clocks into cur_id=2 (cur_id 2 starts at edge 233).
    run_to(233);
    check_val("ca_id2", cur_id, 2);
    run_to(242);
    crs = 1'b1;
    snap = td_cnt;
    run_to(292);
    check_val("ca_no_td", td_cnt - snap, 0);
    check_val("ca_held_id", cur_id, 2);
    crs = 1'b0;
    run_to(293);
    check_val("ca_id3", cur_id, 3);
    run_to(325);
    check_val("ca_beacon", beacon, 1);

    // crs rises exactly on the expiry tick of cur_id 0 (edge 377).
    run_to(376);
    crs = 1'b1;
    run_to(377);
    check_val("sim_to_done", to_done, 0);
    check_val("sim_cur_id", cur_id, 0);
    check_val("sim_tx_op", tx_op, 0);
    run_to(380);
    crs = 1'b0;
    run_to(381);
    check_val("sim_adv_id1", cur_id, 1);
    check_val("sim_adv_td", to_done, 0);

    // Drop plca_en at the 5th clock of the next BEACON (BEACON starts edge 477).
    run_to(481);
    check_val("dis_beacon_on", beacon, 1);
    plca_en = 1'b0;
    run_to(482);
    check_val("dis_beacon", beacon, 0);
    check_val("dis_cur_id", cur_id, 0);

    // Non-coordinator node ID: never beacons.
    local_node_id = 8'd3;
    plca_en = 1'b1;
    snap = bc_cnt;
    run_to(700);
    check_val("id3_no_beacon", bc_cnt - snap, 0);
    check_val("id3_tx_op", tx_op, 0);

    // node_count = 0 acts as a single opportunity: period 52.
    restart(1, 8'd0);
    run_to(21);
    check_val("nc0_tx_op", tx_op, 1);
    run_to(53);
    check_val("nc0_to_done", to_done, 1);
    check_val("nc0_beacon", beacon, 1);
    check_val("nc0_cycle_start", cycle_start, 1);

    // node_count 8 -> 2 while cur_id is 5: next advance returns to BEACON.
    node_count = 8'd8;
    run_to(233);
    check_val("nc8_id5", cur_id, 5);
    run_to(240);
    node_count = 8'd2;
    run_to(264);
    check_val("nc2_no_beacon", beacon, 0);
    run_to(265);
    check_val("nc2_beacon", beacon, 1);
    check_val("nc2_cur_id", cur_id, 0);

    // Tick every 4th clock, node_count = 1.
    restart(4, 8'd1);
    run_to(80);
    check_val("slow_beacon_last", beacon, 1);
    run_to(81);
    check_val("slow_beacon_end", beacon, 0);
    snap = td_cnt;
    run_to(208);
    check_val("slow_no_td", td_cnt - snap, 0);
    run_to(209);
    check_val("slow_to_done", to_done, 1);
    check_val("slow_beacon", beacon, 1);
    check_val("slow_cycle_start", cycle_start, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
